eth_pkt_fifo: RTL

//  Parametrised packet-aware ingress FIFO for one switch port; the N-port switch instantiates PORT_COUNT copies.

---
 rtl/eth_pkt_fifo_if.sv | 37 +++
 rtl/eth_pkt_fifo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/eth_pkt_fifo_if.sv
// Handshake bundle for one eth_pkt_fifo port: ingress word stream, pop request,
// egress word stream and the status/error flags seen by drivers and monitors.
interface eth_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  invalid;
  logic [DATA_WIDTH-1:0] indata;
  logic                  insop;
  logic                  ineop;
  logic                  rd_en;
  logic                  outvalid;
  logic [DATA_WIDTH-1:0] outdata;
  logic                  outsop;
  logic                  outeop;
  logic                  stall_full;
  logic                  stall_empty;
  logic [CNT_W-1:0]      pkt_cnt;
  logic                  err_proto;
  logic                  err_overflow;

  // Traffic source / sink side
  modport master (
    output invalid, indata, insop, ineop, rd_en,
    input  outvalid, outdata, outsop, outeop,
    input  stall_full, stall_empty, pkt_cnt, err_proto, err_overflow
  );

  // FIFO side
  modport slave (
    input  invalid, indata, insop, ineop, rd_en,
    output outvalid, outdata, outsop, outeop,
    output stall_full, stall_empty, pkt_cnt, err_proto, err_overflow
  );
endinterface

// File: rtl/eth_pkt_fifo.sv
// Packet-aware store-and-forward ingress FIFO for one switch port.
// A packet becomes readable only once its eop word is stored, so the head is
// always a complete packet whenever pkt_cnt is non-zero.
// Optional feature macro: ETH_PKT_DROP_EN -- overflow or a stray sop erases
// the partial packet being written and the rest of it is discarded up to its
// eop; adds the drop_cnt port.
//
// Write FSM
//   state  | meaning
//   IDLE   | between packets, next legal word is sop
//   IN_PKT | packet open, accepting middle/eop words
//   DROP   | packet being discarded until its eop (drop build only)
module eth_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic              clk,
  input  logic              rst,
  eth_pkt_fifo_if.slave     bus
`ifdef ETH_PKT_DROP_EN
  ,
  output logic [15:0]       drop_cnt
`endif
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, IN_PKT, DROP} wrState_t;

  wrState_t              state, stateNext;
  logic [DATA_WIDTH+1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wrPtr, rdPtr;
  logic [CNT_W-1:0]      occ, pktCnt;
  logic                  popFire, hasRoom, wrFire, protoErr, ovfErr;
  logic [DATA_WIDTH+1:0] headWord;
`ifdef ETH_PKT_DROP_EN
  logic                  dropNow;
  logic [CNT_W-1:0]      partLen;
`endif

  // A pop only happens when a complete packet sits at the head
  assign popFire  = bus.rd_en && (pktCnt != '0);
  // A pop in the same cycle frees the slot a full FIFO needs for the write
  assign hasRoom  = (occ < CNT_W'(DEPTH)) || popFire;
  assign headWord = mem[rdPtr];

  // Flags derive from registered counters only, never from invalid/rd_en
  assign bus.stall_full  = (occ == CNT_W'(DEPTH));
  assign bus.stall_empty = (pktCnt == '0);
  assign bus.pkt_cnt     = pktCnt;

  // Write-side framing decision: accept, discard, flag errors
  always_comb begin
    stateNext = state;
    wrFire    = 1'b0;
    protoErr  = 1'b0;
    ovfErr    = 1'b0;
`ifdef ETH_PKT_DROP_EN
    dropNow   = 1'b0;
`endif
    if (bus.invalid) begin
      case (state)
        IDLE: begin
          if (!bus.insop) begin
            protoErr = 1'b1;
          end else if (hasRoom) begin
            wrFire    = 1'b1;
            stateNext = bus.ineop ? IDLE : IN_PKT;
          end else begin
            ovfErr = 1'b1;
`ifdef ETH_PKT_DROP_EN
            dropNow   = 1'b1;
            stateNext = bus.ineop ? IDLE : DROP;
`else
            stateNext = bus.ineop ? IDLE : IN_PKT;
`endif
          end
        end
        IN_PKT: begin
          if (bus.insop) begin
            protoErr = 1'b1;
`ifdef ETH_PKT_DROP_EN
            dropNow   = 1'b1;
            stateNext = DROP;
`endif
          end else if (hasRoom) begin
            wrFire = 1'b1;
            if (bus.ineop) stateNext = IDLE;
          end else begin
            ovfErr = 1'b1;
`ifdef ETH_PKT_DROP_EN
            dropNow   = 1'b1;
            stateNext = bus.ineop ? IDLE : DROP;
`else
            if (bus.ineop) stateNext = IDLE;
`endif
          end
        end
        default: begin
          // Discarding the tail of a dropped packet; a sop here is still a framing error
          if (bus.insop) protoErr = 1'b1;
          else if (bus.ineop) stateNext = IDLE;
        end
      endcase
    end
  end

  // Write FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  // Storage array; contents need no reset since pointers/counters gate every read
  always_ff @(posedge clk) begin
    if (wrFire) mem[wrPtr] <= {bus.ineop, bus.insop, bus.indata};
  end

  // Pointers, occupancy and complete-packet count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      occ    <= '0;
      pktCnt <= '0;
    end else begin
      if (wrFire) wrPtr <= wrPtr + 1'b1;
`ifdef ETH_PKT_DROP_EN
      // partLen == DEPTH truncates to 0, which is correct: sop address == wrPtr then
      else if (dropNow) wrPtr <= wrPtr - PTR_W'(partLen);
`endif
      if (popFire) rdPtr <= rdPtr + 1'b1;
`ifdef ETH_PKT_DROP_EN
      occ <= occ + CNT_W'(wrFire) - CNT_W'(popFire) - (dropNow ? partLen : '0);
`else
      occ <= occ + CNT_W'(wrFire) - CNT_W'(popFire);
`endif
      pktCnt <= pktCnt + CNT_W'(wrFire && bus.ineop)
                       - CNT_W'(popFire && headWord[DATA_WIDTH+1]);
    end
  end

`ifdef ETH_PKT_DROP_EN
  // Length of the packet currently being written, and the saturating drop counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      partLen  <= '0;
      drop_cnt <= '0;
    end else begin
      if (wrFire) partLen <= bus.ineop ? '0 : partLen + 1'b1;
      else if (dropNow) partLen <= '0;
      if (dropNow && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

  // Registered pop outputs and error pulses; out* hold when nothing is popped
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.outvalid     <= 1'b0;
      bus.outdata      <= '0;
      bus.outsop       <= 1'b0;
      bus.outeop       <= 1'b0;
      bus.err_proto    <= 1'b0;
      bus.err_overflow <= 1'b0;
    end else begin
      bus.outvalid     <= popFire;
      if (popFire) {bus.outeop, bus.outsop, bus.outdata} <= headWord;
      bus.err_proto    <= protoErr;
      bus.err_overflow <= ovfErr;
    end
  end
endmodule
